// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the BCD <-> binary converters.
// Holds the default widths, the per-digit adjust constants used by the
// double-dabble style algorithms, the converter state encoding and a small
// digit-validity helper.
package bcd_pkg;

  // Default geometry: four BCD digits need 14 bits of binary (9999 < 16384).
  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  // Width of one packed BCD digit.
  localparam int DIGIT_W = 4;

  // Digit correction: a digit that reaches the threshold after a shift
  // is pulled back by the offset (the inverse of the "add 3" step).
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_OFFSET = 3;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // True when a 4-bit code is not a legal decimal digit.
  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
    return (digit > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Combinational per-digit correction used by the reverse double-dabble:
// if the digit is 8 or more it has 3 subtracted, otherwise it passes through.
// Ports:
//   digit_in  - one BCD digit after the right shift
//   digit_out - the corrected digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= DIGIT_W'(ADJ_THRESH)) ?
                     (digit_in - DIGIT_W'(ADJ_OFFSET)) : digit_in;

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin
// Sequential packed-BCD to binary converter using reverse double-dabble.
// A start pulse loads the BCD word; the block then shifts {bcd, bin} right
// once per clock for BIN_W clocks, correcting every digit that lands at 8 or
// more, and finally publishes the binary value with a one-cycle rdy pulse.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   en        - start pulse, bcd_d_in sampled on the same edge (ignored when busy)
//   bcd_d_in  - packed BCD input, digit 0 in bits [3:0]
//   bin_d_out - binary result, held until the next result
//   rdy       - one-cycle pulse, bin_d_out/err valid
//   busy      - conversion in progress
//   err       - last conversion had a digit above 9 (bin_d_out forced to 0)
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_d_in,
  output logic [BIN_W-1:0]          bin_d_out,
  output logic                      rdy,
  output logic                      busy,
  output logic                      err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inv_q, inv_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [BCD_W+BIN_W-1:0] shift_cat;
  logic [BCD_W-1:0]       bcd_shift;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BIN_W-1:0]       bin_shift;
  logic                   in_invalid;

  // One right shift of the combined {bcd, bin} register; a zero enters at
  // the top of the BCD field and the BCD LSB drops into the binary MSB.
  assign shift_cat = {1'b0, bcd_q, bin_q[BIN_W-1:1]};
  assign bcd_shift = shift_cat[BCD_W+BIN_W-1:BIN_W];
  assign bin_shift = shift_cat[BIN_W-1:0];

  // Post-shift digit correction, one unit per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Flag an operand containing any non-decimal digit at load time.
  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_d_in[i*DIGIT_W +: DIGIT_W])) in_invalid = 1'b1;
    end
  end

  // Next-state logic. Outputs are computed here and registered so rdy lands
  // in the cycle after DONE, which is already IDLE and can accept a new en.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          bcd_d   = bcd_d_in;
          bin_d   = '0;
          cnt_d   = '0;
          inv_d   = in_invalid;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // The shift on this edge is the last of BIN_W iterations.
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        bin_out_d = inv_q ? '0 : bin_q;
        err_d     = inv_q;
        rdy_d     = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion and clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bin_d_out = bin_out_q;
  assign err       = err_q;
  assign rdy       = rdy_q;
  assign busy      = busy_q;

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits on the input (supported range 1..4).
REQ-002 Parameter: BIN_W, default 14, binary result width; SHALL be at least ceil(log2(10^DIGITS)).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: en  input  1  start pulse; bcd_d_in is sampled on the same edge.
REQ-006 Port: bcd_d_in  input  4*DIGITS  packed BCD, with digit 0 in bits [3:0].
REQ-007 Port: bin_d_out  output  BIN_W  binary result, held until the next result is published.
REQ-008 Port: rdy  output  1  one-cycle pulse; bin_d_out and err are valid on this cycle.
REQ-009 Port: busy  output  1  high while a conversion is in progress.
REQ-010 Port: err  output  1  the last conversion contained a digit greater than 9; held with bin_d_out.

Function
REQ-011 The block SHALL implement reverse double-dabble using states IDLE, SHIFT and DONE.
REQ-012 IDLE: en=1 SHALL load bcd_d_in into the BCD register, clear the binary shift register and iteration counter, latch an invalid-digit flag, and go to SHIFT.
REQ-013 SHIFT: each cycle SHALL right-shift {bcd_reg, bin_reg} by one, then subtract 3 from every BCD digit whose value is 8 or more after the shift.
REQ-014 SHIFT SHALL last exactly BIN_W cycles, counted by the iteration counter, and then go to DONE.
REQ-015 DONE: the block SHALL publish bin_reg to bin_d_out, assert rdy for that one cycle, and return to IDLE.
REQ-016 Latency SHALL be fixed at BIN_W+1 clocks from the en edge to the rdy cycle (15 at default parameters).
REQ-017 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-018 en SHALL be ignored while busy=1; no queuing.
REQ-019 en in the IDLE cycle immediately after DONE SHALL start a new conversion, giving a back-to-back throughput of one result per BIN_W+2 clocks.
REQ-020 If any loaded digit exceeds 9, the conversion SHALL still run full latency.
REQ-021 For an invalid-digit conversion, the block SHALL publish bin_d_out=0 and err=1 at the rdy cycle.
REQ-022 For a valid conversion, err SHALL be 0.
REQ-023 For valid input, bin_d_out SHALL equal the exact decimal value; no overflow is possible given REQ-002.
REQ-024 bin_d_out and err SHALL change only in the rdy cycle or on reset.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear all registers.
REQ-026 During reset the outputs SHALL be bin_d_out=0, rdy=0, busy=0, err=0.
REQ-027 Reset during SHIFT or DONE SHALL abort the conversion with no rdy pulse.
REQ-028 The first en after reset release SHALL be honoured.

Structure
REQ-029 Package bcd_pkg SHALL hold the DIGITS and BIN_W defaults, the digit width (4), the adjust threshold (8) and offset (3), and the state enum (IDLE, SHIFT, DONE).
REQ-030 bcd_pkg SHALL be shared with the binary-to-BCD converter.
REQ-031 One sub-module, bcd_digit_adj, SHALL be used: a combinational per-digit "if >=8 subtract 3" unit, instantiated DIGITS times.
REQ-032 The iteration counter SHALL be clog2(BIN_W+1) bits wide.

Verification
REQ-033 bcd_d_in=16'h9999, en pulse -> rdy exactly 15 clocks later, bin_d_out=14'd9999 (0x270F), err=0.
REQ-034 Inputs 16'h0000, 16'h1234 and 16'h0010, each converted in turn -> bin_d_out 0, 1234 (0x04D2) and 10 respectively, one rdy pulse each.
REQ-035 en re-pulsed with 16'h5555 while busy -> ignored; a single rdy pulse carrying the first operand's result.
REQ-036 bcd_d_in=16'h12A4 -> rdy after 15 clocks with err=1, bin_d_out=0; the next valid conversion clears err.
REQ-037 rst_n asserted at SHIFT iteration 7 -> outputs zero immediately, no rdy; a new conversion after release completes correctly.
REQ-038 Round-trip check: chained with the binary-to-BCD converter, sweep 0..9999 -> output equals the original binary value for every input.
